// File: rtl/tx_level_mapper.sv
// Transmit-side 16-QAM Gray level mapper with a windowed mean-I^2 power meter.
// Levels scale with a reference level that only changes at window boundaries.

module tx_level_rail (
  input  logic        [1:0]  i_gray,
  input  logic signed [17:0] i_half,
  input  logic signed [17:0] i_outer,
  output logic signed [17:0] o_level
);
  always_comb begin
    o_level = i_outer;
    case (i_gray)
      2'b00:   o_level = -i_outer;
      2'b01:   o_level = -i_half;
      2'b11:   o_level = i_half;
      default: o_level = i_outer;
    endcase
  end
endmodule

module tx_level_mapper #(
  parameter int WIN_LOG2 = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_ena,
  input  logic        [3:0]  sym_in,
  input  logic signed [17:0] ref_level,
  input  logic               clear,
  output logic signed [17:0] i_out,
  output logic signed [17:0] q_out,
  output logic               out_valid,
  output logic        [38:0] tx_power,
  output logic               power_valid
);
  localparam int ACC_W = 36 + WIN_LOG2;
  localparam int RAILS = 2;

  logic signed [17:0]          r_ref_active;
  logic signed [17:0]          r_i_out;
  logic signed [17:0]          r_q_out;
  logic                        r_out_valid;
  logic        [38:0]          r_tx_power;
  logic                        r_power_valid;
  logic        [ACC_W-1:0]     r_acc;
  logic        [WIN_LOG2-1:0]  r_win_cnt;

  logic signed [17:0]          w_ref_clamped;
  logic signed [17:0]          w_half;
  logic signed [18:0]          w_outer_wide;
  logic signed [17:0]          w_outer;
  logic [RAILS-1:0][17:0]      w_level;
  logic        [35:0]          w_sq;
  logic        [ACC_W-1:0]     w_acc_sum;
  logic                        w_win_last;

  assign w_ref_clamped = ref_level[17] ? 18'sd0 : ref_level;

  // Scale stays fixed for a whole window so every sample in it shares one power reference.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_ref_active <= '0;
    else if (r_win_cnt == '0) r_ref_active <= w_ref_clamped;
  end

  assign w_half       = r_ref_active >>> 1;
  assign w_outer_wide = {w_half[17], w_half} + {r_ref_active[17], r_ref_active};

  always_comb begin
    w_outer = w_outer_wide[17:0];
    if (w_outer_wide > 19'sd131071)       w_outer = 18'sd131071;
    else if (w_outer_wide < -19'sd131071) w_outer = -18'sd131071;
  end

  // Rail 0 takes sym_in[3:2] (I), rail 1 takes sym_in[1:0] (Q).
  for (genvar g = 0; g < RAILS; g++) begin : g_rail
    tx_level_rail u_rail (
      .i_gray  (sym_in[3-2*g -: 2]),
      .i_half  (w_half),
      .i_outer (w_outer),
      .o_level (w_level[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i_out     <= '0;
      r_q_out     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= sym_ena;
      if (sym_ena) begin
        r_i_out <= w_level[0];
        r_q_out <= w_level[1];
      end
    end
  end

  assign w_sq       = r_i_out * r_i_out;
  assign w_acc_sum  = r_acc + ACC_W'(w_sq);
  assign w_win_last = (r_win_cnt == '1);

  // clear outranks a coincident sample: that sample is dropped and no window closes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc         <= '0;
      r_win_cnt     <= '0;
      r_tx_power    <= '0;
      r_power_valid <= 1'b0;
    end else begin
      r_power_valid <= 1'b0;
      if (clear) begin
        r_acc     <= '0;
        r_win_cnt <= '0;
      end else if (r_out_valid) begin
        if (w_win_last) begin
          r_tx_power    <= 39'(w_acc_sum >> WIN_LOG2);
          r_power_valid <= 1'b1;
          r_acc         <= '0;
          r_win_cnt     <= '0;
        end else begin
          r_acc     <= w_acc_sum;
          r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
        end
      end
    end
  end

  assign i_out       = r_i_out;
  assign q_out       = r_q_out;
  assign out_valid   = r_out_valid;
  assign tx_power    = r_tx_power;
  assign power_valid = r_power_valid;
endmodule

// File: tb/tb_tx_level_mapper.sv
// Directed bench for tx_level_mapper with a 16-symbol power window.

module tb_tx_level_mapper;
  localparam int WL = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sym_ena = 1'b0;
  logic        [3:0]  sym_in = 4'b0;
  logic signed [17:0] ref_level = 18'sd0;
  logic               clear = 1'b0;
  logic signed [17:0] i_out;
  logic signed [17:0] q_out;
  logic               out_valid;
  logic        [38:0] tx_power;
  logic               power_valid;

  int total = 0;
  int bad   = 0;
  int pv_cnt = 0;

  tx_level_mapper #(.WIN_LOG2(WL)) dut (
    .clk         (clk),
    .reset       (reset),
    .sym_ena     (sym_ena),
    .sym_in      (sym_in),
    .ref_level   (ref_level),
    .clear       (clear),
    .i_out       (i_out),
    .q_out       (q_out),
    .out_valid   (out_valid),
    .tx_power    (tx_power),
    .power_valid (power_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (power_valid === 1'b1) pv_cnt++;
  endtask

  task automatic send(input logic [3:0] s);
    sym_ena = 1'b1;
    sym_in  = s;
    step();
    sym_ena = 1'b0;
  endtask

  // Zero the window, then give ref_active one cycle with win_cnt==0 to load.
  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (i_out !== 18'sd0) begin bad++; $display("FAIL rst_i got=%0d exp=0", i_out); end
    total++; if (q_out !== 18'sd0) begin bad++; $display("FAIL rst_q got=%0d exp=0", q_out); end
    total++; if (out_valid !== 1'b0 || power_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valids got=%b%b exp=00", out_valid, power_valid);
    end
    total++; if (tx_power !== 39'd0) begin bad++; $display("FAIL rst_pwr got=%0d exp=0", tx_power); end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    ref_level = 18'sd4096;
    do_clear();
    for (int k = 0; k < 5; k++) send(4'b1010);
    step();
    total++; if (dut.r_win_cnt !== 4'd5) begin bad++; $display("FAIL mid_cnt got=%0d exp=5", dut.r_win_cnt); end
    total++; if (dut.r_acc === '0) begin bad++; $display("FAIL mid_acc got=0 exp=nonzero"); end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    total++; if (i_out !== 18'sd0 || q_out !== 18'sd0) begin
      bad++; $display("FAIL mid_rst_iq got=%0d,%0d exp=0,0", i_out, q_out);
    end
    total++; if (dut.r_win_cnt !== '0 || dut.r_acc !== '0 || dut.r_ref_active !== 18'sd0) begin
      bad++; $display("FAIL mid_rst_state got=%0d,%0d,%0d exp=0,0,0", dut.r_win_cnt, dut.r_acc, dut.r_ref_active);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    sym_ena = 1'b1;
    sym_in  = 4'b1010;
    pv_cnt  = 0;
    step();
    sym_ena = 1'b0;
    total++; if (i_out !== 18'sd0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL post_rst_map got=%0d/%b exp=0/1", i_out, out_valid);
    end
    for (int k = 0; k < 20; k++) step();
    total++; if (pv_cnt != 0 || tx_power !== 39'd0) begin
      bad++; $display("FAIL post_rst_pv got=%0d/%0d exp=0/0", pv_cnt, tx_power);
    end
  endtask

  task automatic test_map();
    ref_level = 18'sd4096;
    do_clear();
    send(4'b1001);
    total++; if (i_out !== 18'sd6144) begin bad++; $display("FAIL map_i got=%0d exp=6144", i_out); end
    total++; if (q_out !== -18'sd2048) begin bad++; $display("FAIL map_q got=%0d exp=-2048", q_out); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL map_ov got=%b exp=1", out_valid); end
    step();
    total++; if (out_valid !== 1'b0 || i_out !== 18'sd6144) begin
      bad++; $display("FAIL map_hold got=%b/%0d exp=0/6144", out_valid, i_out);
    end
  endtask

  task automatic test_sat();
    ref_level = 18'sd100000;
    do_clear();
    send(4'b1000);
    total++; if (i_out !== 18'sd131071 || q_out !== -18'sd131071) begin
      bad++; $display("FAIL sat_outer got=%0d,%0d exp=131071,-131071", i_out, q_out);
    end
    send(4'b0111);
    total++; if (i_out !== -18'sd50000 || q_out !== 18'sd50000) begin
      bad++; $display("FAIL sat_inner got=%0d,%0d exp=-50000,50000", i_out, q_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]         gseq [4];
    logic signed [17:0] iexp [4];
    gseq = '{2'b00, 2'b01, 2'b11, 2'b10};
    iexp = '{-18'sd6144, -18'sd2048, 18'sd2048, 18'sd6144};
    ref_level = 18'sd4096;
    do_clear();
    pv_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      sym_ena = 1'b1;
      sym_in  = {gseq[k%4], gseq[k%4]};
      step();
      total++; if (i_out !== iexp[k%4] || q_out !== iexp[k%4] || out_valid !== 1'b1) begin
        bad++; $display("FAIL b2b_sym%0d got=%0d,%0d,%b exp=%0d", k, i_out, q_out, out_valid, iexp[k%4]);
      end
    end
    sym_ena = 1'b0;
    total++; if (pv_cnt != 0) begin bad++; $display("FAIL b2b_early_pv got=%0d exp=0", pv_cnt); end
    step();
    total++; if (power_valid !== 1'b1 || tx_power !== 39'd20971520) begin
      bad++; $display("FAIL b2b_pwr got=%b/%0d exp=1/20971520", power_valid, tx_power);
    end
    step();
    total++; if (power_valid !== 1'b0 || pv_cnt != 1) begin
      bad++; $display("FAIL b2b_pv_once got=%b/%0d exp=0/1", power_valid, pv_cnt);
    end
  endtask

  task automatic test_ref_freeze();
    ref_level = 18'sd4096;
    do_clear();
    for (int k = 0; k < 3; k++) send(4'b1111);
    step();
    total++; if (dut.r_win_cnt !== 4'd3) begin bad++; $display("FAIL frz_cnt got=%0d exp=3", dut.r_win_cnt); end
    ref_level = 18'sd8192;
    pv_cnt = 0;
    for (int k = 0; k < 13; k++) begin
      send(4'b1111);
      total++; if (i_out !== 18'sd2048 || q_out !== 18'sd2048) begin
        bad++; $display("FAIL frz_sym%0d got=%0d,%0d exp=2048", k, i_out, q_out);
      end
    end
    step();
    total++; if (power_valid !== 1'b1 || tx_power !== 39'd4194304) begin
      bad++; $display("FAIL frz_pwr got=%b/%0d exp=1/4194304", power_valid, tx_power);
    end
    step();
    send(4'b1111);
    total++; if (i_out !== 18'sd4096 || q_out !== 18'sd4096) begin
      bad++; $display("FAIL frz_newwin got=%0d,%0d exp=4096", i_out, q_out);
    end
  endtask

  task automatic test_clear();
    ref_level = 18'sd4096;
    do_clear();
    pv_cnt = 0;
    for (int k = 0; k < 7; k++) send(4'b1010);
    sym_ena = 1'b1;
    sym_in  = 4'b1010;
    step();
    sym_ena = 1'b0;
    clear   = 1'b1;
    step();
    clear   = 1'b0;
    total++; if (dut.r_win_cnt !== '0 || dut.r_acc !== '0) begin
      bad++; $display("FAIL clr_state got=%0d,%0d exp=0,0", dut.r_win_cnt, dut.r_acc);
    end
    total++; if (i_out !== 18'sd6144 || tx_power !== 39'd4194304 || pv_cnt != 0) begin
      bad++; $display("FAIL clr_hold got=%0d/%0d/%0d exp=6144/4194304/0", i_out, tx_power, pv_cnt);
    end
    for (int k = 0; k < 16; k++) send((k < 4) ? 4'b1010 : 4'b1111);
    total++; if (pv_cnt != 0) begin bad++; $display("FAIL clr_early_pv got=%0d exp=0", pv_cnt); end
    step();
    total++; if (power_valid !== 1'b1 || tx_power !== 39'd12582912) begin
      bad++; $display("FAIL clr_pwr got=%b/%0d exp=1/12582912", power_valid, tx_power);
    end
    ref_level = -18'sd5;
    step();
    send(4'b1010);
    total++; if (i_out !== 18'sd0 || q_out !== 18'sd0) begin
      bad++; $display("FAIL neg_ref got=%0d,%0d exp=0,0", i_out, q_out);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_map();
    test_sat();
    test_back_to_back();
    test_ref_freeze();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
